// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes,
// and the per-icode source/destination register selection.
package y86_pkg;

    typedef logic [3:0] reg_id_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RSP   = 4'h4;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    typedef struct packed {
        reg_id_t src_a;
        reg_id_t src_b;
        reg_id_t dst_e;
        reg_id_t dst_m;
    } regsel_t;

    // Register IDs read and written by each instruction class; RNONE elsewhere.
    function automatic regsel_t decode_regs(input logic [3:0] icode,
                                            input reg_id_t ra,
                                            input reg_id_t rb);
        regsel_t r;
        r = '{RNONE, RNONE, RNONE, RNONE};
        case (icode)
            I_RRMOVQ: begin r.src_a = ra;  r.dst_e = rb;  end
            I_IRMOVQ: begin r.dst_e = rb;  end
            I_RMMOVQ: begin r.src_a = ra;  r.src_b = rb;  end
            I_MRMOVQ: begin r.src_b = rb;  r.dst_m = ra;  end
            I_OPQ:    begin r.src_a = ra;  r.src_b = rb;  r.dst_e = rb;  end
            I_CALL:   begin r.src_b = RSP; r.dst_e = RSP; end
            I_RET:    begin r.src_a = RSP; r.src_b = RSP; r.dst_e = RSP; end
            I_PUSHQ:  begin r.src_a = ra;  r.src_b = RSP; r.dst_e = RSP; end
            I_POPQ:   begin r.src_a = RSP; r.src_b = RSP; r.dst_e = RSP; r.dst_m = ra; end
            default:  ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two combinational read ports, two write ports.
// When both write ports target the same register the M port wins, so that
// popq %rsp leaves the popped value in %rsp.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int SP_INIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  reg_id_t           rd_a_id,
    input  reg_id_t           rd_b_id,
    output logic [DATA_W-1:0] rd_a_val,
    output logic [DATA_W-1:0] rd_b_val,
    input  reg_id_t           wr_e_id,
    input  logic [DATA_W-1:0] wr_e_val,
    input  reg_id_t           wr_m_id,
    input  logic [DATA_W-1:0] wr_m_val
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next register contents: E write first, M write overrides on collision.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_e_id != RNONE && int'(wr_e_id) == i) regs_d[i] = wr_e_val;
            if (wr_m_id != RNONE && int'(wr_m_id) == i) regs_d[i] = wr_m_val;
        end
    end

    // Register storage; reset clears everything except the stack pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == int'(RSP)) ? DATA_W'(SP_INIT) : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational reads; IDs beyond the implemented range read as zero.
    always_comb begin
        rd_a_val = '0;
        rd_b_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_a_id) == i) rd_a_val = regs_q[i];
            if (int'(rd_b_id) == i) rd_b_val = regs_q[i];
        end
    end

endmodule

// File: rtl/y86_decode_unit.sv
// Y86-64 decode stage: D pipeline register, register file, src/dst selection,
// operand forwarding and load-use detection.
// Build option DECODE_FWD_EN: when defined, operands are forwarded from the
// E/M/W buses; when undefined, operands come only from the register file and
// d_loaduse flags every read-after-write hazard so control can stall.
module y86_decode_unit
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int SP_INIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [DATA_W-1:0] f_valC,
    input  logic [DATA_W-1:0] f_valP,
    input  logic [3:0]        f_stat,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_dstM,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [3:0]        D_stat,
    output logic [DATA_W-1:0] D_valC,
    output logic [DATA_W-1:0] D_valP,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB,
    output logic              d_loaduse
);

    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [3:0]        stat;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] valp;
    } dreg_t;

    dreg_t             dreg_q, dreg_d;
    regsel_t           sel;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              load_hazard;
    reg_id_t [4:0]     bus_ids;

    // Index 0 is the highest forwarding priority (youngest producer first).
    assign bus_ids = {W_dstE, W_dstM, M_dstE, M_dstM, e_dstE};

    // Returns true when a real source register is being produced on any bus.
    function automatic logic any_match(input reg_id_t src, input reg_id_t [4:0] ids);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 5; i++)
            if (ids[i] != RNONE && ids[i] == src) hit = 1'b1;
        return hit;
    endfunction

    // D register next state: stall holds, bubble injects a NOP keeping f_stat.
    always_comb begin
        dreg_d = dreg_q;
        if (!D_stall && D_bubble) begin
            dreg_d.icode = I_NOP;
            dreg_d.stat  = f_stat;
        end else if (!D_stall) begin
            dreg_d = '{f_icode, f_ifun, f_rA, f_rB, f_stat, f_valC, f_valP};
        end
    end

    // D register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dreg_q       <= '0;
            dreg_q.icode <= I_NOP;
            dreg_q.stat  <= S_AOK;
        end else begin
            dreg_q <= dreg_d;
        end
    end

    assign D_icode = dreg_q.icode;
    assign D_ifun  = dreg_q.ifun;
    assign D_rA    = dreg_q.ra;
    assign D_rB    = dreg_q.rb;
    assign D_stat  = dreg_q.stat;
    assign D_valC  = dreg_q.valc;
    assign D_valP  = dreg_q.valp;

    assign sel    = decode_regs(dreg_q.icode, dreg_q.ra, dreg_q.rb);
    assign d_srcA = sel.src_a;
    assign d_srcB = sel.src_b;
    assign d_dstE = sel.dst_e;
    assign d_dstM = sel.dst_m;

    y86_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SP_INIT  (SP_INIT)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rd_a_id  (sel.src_a),
        .rd_b_id  (sel.src_b),
        .rd_a_val (rf_a),
        .rd_b_val (rf_b),
        .wr_e_id  (W_dstE),
        .wr_e_val (W_valE),
        .wr_m_id  (W_dstM),
        .wr_m_val (W_valM)
    );

    assign load_hazard = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != RNONE &&
                         (E_dstM == sel.src_a || E_dstM == sel.src_b);

`ifdef DECODE_FWD_EN
    logic [4:0][DATA_W-1:0] bus_vals;
    assign bus_vals = {W_valE, W_valM, M_valE, m_valM, e_valE};

    // Highest-priority bus match wins, otherwise the register file value.
    function automatic logic [DATA_W-1:0] fwd_sel(input reg_id_t src,
                                                  input logic [DATA_W-1:0] rf_val,
                                                  input reg_id_t [4:0] ids,
                                                  input logic [4:0][DATA_W-1:0] vals);
        logic [DATA_W-1:0] v;
        v = rf_val;
        for (int i = 4; i >= 0; i--)
            if (ids[i] == src) v = vals[i];
        if (src == RNONE) v = '0;
        return v;
    endfunction

    // Forwarded operands; jXX/call carry the fall-through PC in valA.
    always_comb begin
        d_valB = fwd_sel(sel.src_b, rf_b, bus_ids, bus_vals);
        d_valA = fwd_sel(sel.src_a, rf_a, bus_ids, bus_vals);
        if (dreg_q.icode == I_JXX || dreg_q.icode == I_CALL) d_valA = dreg_q.valp;
    end

    assign d_loaduse = load_hazard;
`else
    logic unused_fwd_vals;
    assign unused_fwd_vals = ^{e_valE, M_valE, m_valM};

    // Register-file-only operands; jXX/call carry the fall-through PC in valA.
    always_comb begin
        d_valB = (sel.src_b == RNONE) ? '0 : rf_b;
        d_valA = (sel.src_a == RNONE) ? '0 : rf_a;
        if (dreg_q.icode == I_JXX || dreg_q.icode == I_CALL) d_valA = dreg_q.valp;
    end

    // Without forwarding every pending producer is a hazard; a load sitting in
    // E is also one, since its target appears on none of the buses yet.
    assign d_loaduse = load_hazard ||
                       any_match(sel.src_a, bus_ids) || any_match(sel.src_b, bus_ids);
`endif

endmodule

// File: tb/tb_y86_decode_unit.sv
// Self-checking bench for y86_decode_unit: a decode vector table, hand-written
// multi-cycle sequences, then randomized cycles against a reference model.
module tb_y86_decode_unit;

    localparam int DW = 64;
    localparam logic [3:0] NONE = 4'hF;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    f_icode, f_ifun, f_rA, f_rB, f_stat;
    logic [DW-1:0] f_valC, f_valP;
    logic          D_stall, D_bubble;
    logic [3:0]    e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]    E_icode, E_dstM;
    logic [3:0]    D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [DW-1:0] D_valC, D_valP;
    logic [3:0]    d_srcA, d_srcB, d_dstE, d_dstM;
    logic [DW-1:0] d_valA, d_valB;
    logic          d_loaduse;

    int checks = 0;
    int failures = 0;

    y86_decode_unit #(.DATA_W(DW), .NUM_REGS(15), .SP_INIT(16)) dut (
        .clk(clk), .reset(reset),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
        .E_icode(E_icode), .E_dstM(E_dstM),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
        .D_valC(D_valC), .D_valP(D_valP),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB), .d_loaduse(d_loaduse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [15];
    logic [3:0]    m_icode, m_ifun, m_ra, m_rb, m_stat;
    logic [DW-1:0] m_valc, m_valp;

    // Register role per icode: 0 none, 1 rA, 2 rB, 3 %rsp.
    int sel_a [16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
    int sel_b [16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
    int sel_e [16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
    int sel_m [16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};

    function automatic logic [3:0] pick(int s, logic [3:0] ra, logic [3:0] rb);
        case (s)
            1: return ra;
            2: return rb;
            3: return 4'd4;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_operand(logic [3:0] src);
        logic [3:0]    ids  [5];
        logic [DW-1:0] vals [5];
        if (src == NONE) return '0;
        ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
`ifdef DECODE_FWD_EN
        foreach (ids[i]) if (ids[i] == src) return vals[i];
`endif
        return m_regs[src];
    endfunction

    function automatic logic m_loaduse(logic [3:0] sa, logic [3:0] sb);
        logic [3:0] ids [5];
        logic       lu;
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != NONE && (E_dstM == sa || E_dstM == sb);
`ifndef DECODE_FWD_EN
        ids = '{e_dstE, M_dstE, M_dstM, W_dstE, W_dstM};
        foreach (ids[i]) if (ids[i] != NONE && (ids[i] == sa || ids[i] == sb)) lu = 1'b1;
`endif
        return lu;
    endfunction

    task automatic m_reset();
        foreach (m_regs[i]) m_regs[i] = (i == 4) ? 64'd16 : 64'd0;
        m_icode = 4'h1; m_stat = 4'h1;
        m_ifun = '0; m_ra = '0; m_rb = '0; m_valc = '0; m_valp = '0;
    endtask

    task automatic m_clock();
        if (W_dstE != NONE) m_regs[W_dstE] = W_valE;
        if (W_dstM != NONE) m_regs[W_dstM] = W_valM;
        if (D_stall) begin
        end else if (D_bubble) begin
            m_icode = 4'h1; m_stat = f_stat;
        end else begin
            m_icode = f_icode; m_ifun = f_ifun; m_ra = f_rA; m_rb = f_rB;
            m_stat = f_stat; m_valc = f_valC; m_valp = f_valP;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [3:0] sa, sb;
        sa = pick(sel_a[m_icode], m_ra, m_rb);
        sb = pick(sel_b[m_icode], m_ra, m_rb);
        chk({tag, " D_icode"}, D_icode, m_icode);
        chk({tag, " D_ifun"},  D_ifun,  m_ifun);
        chk({tag, " D_rA"},    D_rA,    m_ra);
        chk({tag, " D_rB"},    D_rB,    m_rb);
        chk({tag, " D_stat"},  D_stat,  m_stat);
        chk({tag, " D_valC"},  D_valC,  m_valc);
        chk({tag, " D_valP"},  D_valP,  m_valp);
        chk({tag, " d_srcA"},  d_srcA,  sa);
        chk({tag, " d_srcB"},  d_srcB,  sb);
        chk({tag, " d_dstE"},  d_dstE,  pick(sel_e[m_icode], m_ra, m_rb));
        chk({tag, " d_dstM"},  d_dstM,  pick(sel_m[m_icode], m_ra, m_rb));
        chk({tag, " d_valA"},  d_valA,
            (m_icode == 4'h7 || m_icode == 4'h8) ? m_valp : m_operand(sa));
        chk({tag, " d_valB"},  d_valB,  m_operand(sb));
        chk({tag, " d_loaduse"}, {63'd0, d_loaduse}, {63'd0, m_loaduse(sa, sb)});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) m_clock();
        @(negedge clk);
    endtask

    task automatic idle_buses();
        e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        E_icode = 4'h0; E_dstM = NONE; D_stall = 0; D_bubble = 0;
    endtask

    task automatic load_d(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb);
        idle_buses();
        f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb; f_stat = 4'h1;
        f_valC = 64'h55; f_valP = 64'h200;
        tick();
    endtask

    typedef struct {
        logic [3:0]    icode, ra, rb, e_icode, e_dstm;
        logic [3:0]    srca, srcb, dste, dstm;
        logic [DW-1:0] vala, valb;
        logic          lu;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{4'h0, 4'h2, 4'h3, 4'h5, 4'h2, NONE, NONE, NONE, NONE, 64'h0,   64'h0,  1'b0};
        vecs[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, NONE, NONE, NONE, NONE, NONE, 64'h0,   64'h0,  1'b0};
        vecs[2]  = '{4'h2, 4'h4, 4'h1, 4'h5, 4'h4, 4'h4, NONE, 4'h1, NONE, 64'd16,  64'h0,  1'b1};
        vecs[3]  = '{4'h3, NONE, 4'h5, 4'hB, 4'h5, NONE, NONE, 4'h5, NONE, 64'h0,   64'h0,  1'b0};
        vecs[4]  = '{4'h4, 4'h6, 4'h4, 4'hB, 4'h4, 4'h6, 4'h4, NONE, NONE, 64'h0,   64'd16, 1'b1};
        vecs[5]  = '{4'h5, 4'h7, 4'h4, 4'h6, 4'h4, NONE, 4'h4, NONE, 4'h7, 64'h0,   64'd16, 1'b0};
        vecs[6]  = '{4'h6, 4'h4, 4'h4, 4'h5, NONE, 4'h4, 4'h4, 4'h4, NONE, 64'd16,  64'd16, 1'b0};
        vecs[7]  = '{4'h7, 4'h4, 4'h4, 4'h5, 4'h4, NONE, NONE, NONE, NONE, 64'h107, 64'h0,  1'b0};
        vecs[8]  = '{4'h8, 4'h2, 4'h3, 4'h5, 4'h4, NONE, 4'h4, 4'h4, NONE, 64'h108, 64'd16, 1'b1};
        vecs[9]  = '{4'h9, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, NONE, 64'd16,  64'd16, 1'b0};
        vecs[10] = '{4'hA, 4'h3, NONE, 4'h5, 4'h3, 4'h3, 4'h4, 4'h4, NONE, 64'h0,   64'd16, 1'b1};
        vecs[11] = '{4'hB, 4'h2, NONE, 4'hB, NONE, 4'h4, 4'h4, 4'h4, 4'h2, 64'd16,  64'd16, 1'b0};
        vecs[12] = '{4'hC, 4'h4, 4'h4, 4'h5, 4'h4, NONE, NONE, NONE, NONE, 64'h0,   64'h0,  1'b0};
        vecs[13] = '{4'hF, 4'h4, 4'h4, 4'h5, 4'h4, NONE, NONE, NONE, NONE, 64'h0,   64'h0,  1'b0};

        // Reset with no clock edge taken yet.
        reset = 1'b1;
        idle_buses();
        f_icode = 4'h0; f_ifun = 4'h0; f_rA = 4'h0; f_rB = 4'h0; f_stat = 4'h1;
        f_valC = '0; f_valP = '0;
        m_reset();
        #2;
        chk("reset D_icode", D_icode, 4'h1);
        chk("reset D_stat",  D_stat,  4'h1);
        chk("reset D_valP",  D_valP,  64'h0);
        chk("reset d_srcA",  d_srcA,  NONE);
        chk("reset d_srcB",  d_srcB,  NONE);
        chk("reset d_valA",  d_valA,  64'h0);
        chk("reset d_valB",  d_valB,  64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Decode table: register file still in its reset state.
        for (int i = 0; i < 14; i++) begin
            idle_buses();
            f_icode = vecs[i].icode; f_ifun = 4'h0; f_rA = vecs[i].ra; f_rB = vecs[i].rb;
            f_stat = 4'h1; f_valC = 64'h33; f_valP = 64'h100 + 64'(i);
            tick();
            E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm;
            #1;
            chk($sformatf("vec%0d D_icode", i), D_icode, vecs[i].icode);
            chk($sformatf("vec%0d d_srcA", i), d_srcA, vecs[i].srca);
            chk($sformatf("vec%0d d_srcB", i), d_srcB, vecs[i].srcb);
            chk($sformatf("vec%0d d_dstE", i), d_dstE, vecs[i].dste);
            chk($sformatf("vec%0d d_dstM", i), d_dstM, vecs[i].dstm);
            chk($sformatf("vec%0d d_valA", i), d_valA, vecs[i].vala);
            chk($sformatf("vec%0d d_valB", i), d_valB, vecs[i].valb);
            chk($sformatf("vec%0d d_loaduse", i), {63'd0, d_loaduse}, {63'd0, vecs[i].lu});
        end

        // Stall beats bubble; bubble alone injects NOP with the fetch status.
        load_d(4'h2, 4'h0, 4'h3);
        f_icode = 4'h6; f_rB = 4'h5; f_stat = 4'h3; D_stall = 1; D_bubble = 1;
        tick(); #1;
        chk("stall D_icode", D_icode, 4'h2);
        chk("stall D_stat",  D_stat,  4'h1);
        chk("stall D_rB",    D_rB,    4'h3);
        D_stall = 0; f_stat = 4'h2;
        tick(); #1;
        chk("bubble D_icode", D_icode, 4'h1);
        chk("bubble D_stat",  D_stat,  4'h2);
        chk("bubble D_rB",    D_rB,    4'h3);

        // W-stage value for rrmovq %rax,%rbx, then visible from the register file.
        load_d(4'h2, 4'h0, 4'h3);
        W_dstE = 4'h0; W_valE = 64'd5;
        #1;
`ifdef DECODE_FWD_EN
        chk("wfwd d_valA", d_valA, 64'd5);
        chk("wfwd d_loaduse", {63'd0, d_loaduse}, 64'd0);
`else
        chk("wraw d_valA", d_valA, 64'd0);
        chk("wraw d_loaduse", {63'd0, d_loaduse}, 64'd1);
`endif
        tick();
        idle_buses(); #1;
        chk("wb d_valA", d_valA, 64'd5);
        chk("wb d_loaduse", {63'd0, d_loaduse}, 64'd0);

        // e-stage beats M-stage on the same source.
        load_d(4'h6, 4'h0, 4'h1);
        e_dstE = 4'h0; e_valE = 64'd7; M_dstE = 4'h0; M_valE = 64'd9;
        #1;
`ifdef DECODE_FWD_EN
        chk("prio d_valA", d_valA, 64'd7);
        chk("prio d_loaduse", {63'd0, d_loaduse}, 64'd0);
`else
        chk("prio d_valA", d_valA, 64'd5);
        chk("prio d_loaduse", {63'd0, d_loaduse}, 64'd1);
`endif

        // Load in E feeding OPq %rbx,%rcx.
        load_d(4'h6, 4'h3, 4'h1);
        E_icode = 4'h5; E_dstM = 4'h3; #1;
        chk("lu hit", {63'd0, d_loaduse}, 64'd1);
        E_dstM = NONE; #1;
        chk("lu none", {63'd0, d_loaduse}, 64'd0);

        // popq %rsp style dual write: M port wins.
        load_d(4'hA, 4'h3, NONE);
        W_dstE = 4'h4; W_valE = 64'd8; W_dstM = 4'h4; W_valM = 64'd24;
        #1;
`ifdef DECODE_FWD_EN
        chk("dualw fwd d_valB", d_valB, 64'd24);
`else
        chk("dualw raw d_valB", d_valB, 64'd16);
        chk("dualw raw d_loaduse", {63'd0, d_loaduse}, 64'd1);
`endif
        tick();
        idle_buses(); #1;
        chk("dualw reg4", d_valB, 64'd24);
        M_dstE = 4'h3; M_valE = 64'd77; #1;
`ifdef DECODE_FWD_EN
        chk("mraw fwd d_valA", d_valA, 64'd77);
        chk("mraw fwd d_loaduse", {63'd0, d_loaduse}, 64'd0);
`else
        chk("mraw d_loaduse", {63'd0, d_loaduse}, 64'd1);
`endif
        idle_buses();

        // Randomized cycles against the model, with one asynchronous reset.
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [3:0] ids [5];
            logic [3:0] loads [4];
            loads = '{4'h5, 4'hB, 4'h6, 4'h2};
            f_icode = 4'($urandom_range(0, 15)); f_ifun = 4'($urandom_range(0, 15));
            f_rA = 4'($urandom_range(0, 15)); f_rB = 4'($urandom_range(0, 15));
            f_stat = 4'($urandom_range(1, 4));
            f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
            D_stall = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 5) == 0);
            foreach (ids[i]) begin
                int r;
                r = $urandom_range(0, 24);
                ids[i] = (r > 15) ? NONE : 4'(r);
            end
            e_dstE = ids[0]; M_dstE = ids[1]; M_dstM = ids[2]; W_dstE = ids[3]; W_dstM = ids[4];
            e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
            m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            E_icode = loads[$urandom_range(0, 3)];
            E_dstM = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom_range(0, 14));
            if (cyc == 200) begin
                #2 reset = 1'b1;
                m_reset();
                #1;
                chk("midreset D_icode", D_icode, 4'h1);
                chk("midreset D_stat", D_stat, 4'h1);
                check_all("midreset");
                @(negedge clk);
                reset = 1'b0;
            end else begin
                #1;
                check_all($sformatf("rnd%0d", cyc));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
